// File: rtl/sipo_deser_pkg.sv
// Shared types and constants for the serial-in/parallel-out deserializer.
// Optional macro SIPO_PARITY_EN adds a trailing even-parity bit per word.
package sipo_pkg;

  localparam int SIPO_WIDTH = 32'd8;

  typedef enum logic [0:0] {
    SHIFT = 1'b0,
    FULL  = 1'b1
  } state_e;

  function automatic int cnt_width(input int width);
`ifdef SIPO_PARITY_EN
    return $clog2(width + 32'd2);
`else
    return $clog2(width + 32'd1);
`endif
  endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Serial input and parallel output handshake bundle of sipo_deser.
// Carries out_perr only when SIPO_PARITY_EN is defined.
interface sipo_deser_if #(
  parameter int WIDTH = sipo_pkg::SIPO_WIDTH,
  parameter int CNT_W = sipo_pkg::cnt_width(WIDTH)
) ();

  logic             ser_in;
  logic             ser_valid;
  logic             ser_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] bit_cnt;
`ifdef SIPO_PARITY_EN
  logic             out_perr;

  modport master (
    output ser_in, ser_valid, out_ready,
    input  ser_ready, out_data, out_valid, bit_cnt, out_perr
  );

  modport slave (
    input  ser_in, ser_valid, out_ready,
    output ser_ready, out_data, out_valid, bit_cnt, out_perr
  );
`else
  modport master (
    output ser_in, ser_valid, out_ready,
    input  ser_ready, out_data, out_valid, bit_cnt
  );

  modport slave (
    input  ser_in, ser_valid, out_ready,
    output ser_ready, out_data, out_valid, bit_cnt
  );
`endif

endinterface

// File: rtl/sipo_deser_shift_core.sv
// Shift register and bit counter; exposes the word being completed this cycle
// and the word parked after completion. SIPO_PARITY_EN adds a parity-bit slot.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             accept,
  input  logic             take,
  input  logic             ser_in,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             done,
  output logic [WIDTH-1:0] held_word,
  output logic [WIDTH-1:0] next_word
`ifdef SIPO_PARITY_EN
  ,
  output logic             held_pbit,
  output logic             next_pbit
`endif
);

`ifdef SIPO_PARITY_EN
  localparam int NBITS = WIDTH + 32'd1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBITS - 32'd1);

  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] shifted_s;
  logic [CNT_W-1:0] cnt_r;
  logic             data_bit_s;
`ifdef SIPO_PARITY_EN
  logic             pbit_r;
`endif

  // Shift direction selection and data/parity slot decode
  always_comb begin
    shifted_s  = shift_r;
    data_bit_s = (cnt_r < CNT_W'(WIDTH));
    if (MSB_FIRST) begin
      shifted_s = {shift_r[WIDTH-2:0], ser_in};
    end else begin
      shifted_s = {ser_in, shift_r[WIDTH-1:1]};
    end
  end

  // Shift register and counter; a taken word restarts collection from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
`ifdef SIPO_PARITY_EN
      pbit_r  <= 1'b0;
`endif
    end else if (clear || take) begin
      shift_r <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
`ifdef SIPO_PARITY_EN
      pbit_r  <= 1'b0;
`endif
    end else if (accept) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      if (data_bit_s) begin
        shift_r <= shifted_s;
      end
`ifdef SIPO_PARITY_EN
      if (!data_bit_s) begin
        pbit_r <= ser_in;
      end
`endif
    end
  end

  assign bit_cnt   = cnt_r;
  assign done      = accept && (cnt_r == LAST);
  assign held_word = shift_r;
`ifdef SIPO_PARITY_EN
  // The final accept is the parity bit, so the data is already complete.
  assign next_word = shift_r;
  assign held_pbit = pbit_r;
  assign next_pbit = ser_in;
`else
  assign next_word = shifted_s;
`endif

endmodule

// File: rtl/sipo_deser.sv
// Double-buffered serial-to-parallel deserializer with ready/valid on both sides.
// Define SIPO_PARITY_EN for a trailing even-parity bit and the out_perr flag.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  sipo_deser_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e           state_r;
  state_e           state_n;
  logic             ser_ready_s;
  logic             accept_s;
  logic             done_s;
  logic             take_s;
  logic [CNT_W-1:0] bit_cnt_s;
  logic [WIDTH-1:0] held_word_s;
  logic [WIDTH-1:0] next_word_s;
  logic [WIDTH-1:0] load_word_s;
  logic [WIDTH-1:0] out_data_r;
  logic             out_valid_r;
`ifdef SIPO_PARITY_EN
  logic             held_pbit_s;
  logic             next_pbit_s;
  logic             load_perr_s;
  logic             out_perr_r;

  function automatic logic parity_err(input logic [WIDTH-1:0] data, input logic pbit);
    return ^{data, pbit};
  endfunction
`endif

  // ser_ready comes from state alone, keeping out_ready off the input path.
  assign ser_ready_s = (state_r == SHIFT);
  assign accept_s    = bus.ser_valid && ser_ready_s;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .CNT_W     (CNT_W)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .accept    (accept_s),
    .take      (take_s),
    .ser_in    (bus.ser_in),
    .bit_cnt   (bit_cnt_s),
    .done      (done_s),
    .held_word (held_word_s),
    .next_word (next_word_s)
`ifdef SIPO_PARITY_EN
    ,
    .held_pbit (held_pbit_s),
    .next_pbit (next_pbit_s)
`endif
  );

  // Next-state and output-slot load decision
  always_comb begin
    state_n     = state_r;
    take_s      = 1'b0;
    load_word_s = next_word_s;
`ifdef SIPO_PARITY_EN
    load_perr_s = parity_err(next_word_s, next_pbit_s);
`endif
    if (clear) begin
      state_n = SHIFT;
    end else begin
      case (state_r)
        SHIFT: begin
          if (done_s && (!out_valid_r || bus.out_ready)) begin
            take_s  = 1'b1;
            state_n = SHIFT;
          end else if (done_s) begin
            state_n = FULL;
          end else begin
            state_n = SHIFT;
          end
        end
        FULL: begin
          load_word_s = held_word_s;
`ifdef SIPO_PARITY_EN
          load_perr_s = parity_err(held_word_s, held_pbit_s);
`endif
          if (bus.out_ready) begin
            take_s  = 1'b1;
            state_n = SHIFT;
          end else begin
            state_n = FULL;
          end
        end
        default: begin
          state_n = SHIFT;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= SHIFT;
    end else begin
      state_r <= state_n;
    end
  end

  // Output holding register; a new word replaces a consumed one without a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
`ifdef SIPO_PARITY_EN
      out_perr_r  <= 1'b0;
`endif
    end else if (clear) begin
      out_valid_r <= 1'b0;
    end else if (take_s) begin
      out_data_r  <= load_word_s;
      out_valid_r <= 1'b1;
`ifdef SIPO_PARITY_EN
      out_perr_r  <= load_perr_s;
`endif
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.ser_ready = ser_ready_s;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.bit_cnt   = bit_cnt_s;
`ifdef SIPO_PARITY_EN
  assign bus.out_perr  = out_perr_r;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: MSB-first and LSB-first instances share stimulus and are
// compared every cycle against a word-level model; SIPO_PARITY_EN supported.
module tb_sipo_deser;

`ifdef SIPO_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  int   checks = 0;
  int   failures = 0;

  sipo_deser_if #(.WIDTH(8)) bus_m ();
  sipo_deser_if #(.WIDTH(8)) bus_l ();

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_m.slave)
  );
  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_l.slave)
  );

  always #5 clk = ~clk;

  // Word-level reference model, index 0 = MSB-first, 1 = LSB-first
  int         m_cnt [2];
  logic [7:0] m_word [2];
  logic       m_x [2];
  logic       m_pend [2];
  logic [7:0] m_pword [2];
  logic       m_pperr [2];
  logic       m_ov [2];
  logic [7:0] m_od [2];
  logic       m_operr [2];

  typedef struct {
    logic [7:0] stream;   // bits sent stream[7] first
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
  } vec_t;
  vec_t vecs [8];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_word[k] = 8'h00; m_x[k] = 1'b0; m_pend[k] = 1'b0;
      m_pword[k] = 8'h00; m_pperr[k] = 1'b0; m_ov[k] = 1'b0;
      m_od[k] = 8'h00; m_operr[k] = 1'b0;
    end
  endfunction

  function automatic void model_step(int k, logic sv, logic b, logic ordy, logic clr);
    logic acc, consumed, loaded;
    acc = sv && !m_pend[k];
    if (clr) begin
      m_cnt[k] = 0; m_word[k] = 8'h00; m_x[k] = 1'b0; m_pend[k] = 1'b0; m_ov[k] = 1'b0;
      return;
    end
    consumed = m_ov[k] && ordy;
    loaded = 1'b0;
    if (m_pend[k] && ordy) begin
      m_od[k] = m_pword[k]; m_operr[k] = m_pperr[k];
      m_pend[k] = 1'b0; m_cnt[k] = 0; loaded = 1'b1;
    end else if (acc) begin
      if (m_cnt[k] < 8) begin
        if (k == 0) m_word[k] = (m_word[k] << 1) | 8'(b);
        else        m_word[k] = m_word[k] | (8'(b) << m_cnt[k]);
      end
      m_x[k] = m_x[k] ^ b;
      m_cnt[k] = m_cnt[k] + 1;
      if (m_cnt[k] == NB) begin
        if (!m_ov[k] || ordy) begin
          m_od[k] = m_word[k]; m_operr[k] = m_x[k]; m_cnt[k] = 0; loaded = 1'b1;
        end else begin
          m_pend[k] = 1'b1; m_pword[k] = m_word[k]; m_pperr[k] = m_x[k];
        end
        m_word[k] = 8'h00; m_x[k] = 1'b0;
      end
    end
    if (loaded) m_ov[k] = 1'b1;
    else if (consumed) m_ov[k] = 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_models();
    chk("m_valid", 32'(bus_m.out_valid), 32'(m_ov[0]));
    chk("m_data",  32'(bus_m.out_data),  32'(m_od[0]));
    chk("m_ready", 32'(bus_m.ser_ready), 32'(!m_pend[0]));
    chk("m_cnt",   32'(bus_m.bit_cnt),   32'(m_cnt[0]));
    chk("l_valid", 32'(bus_l.out_valid), 32'(m_ov[1]));
    chk("l_data",  32'(bus_l.out_data),  32'(m_od[1]));
    chk("l_ready", 32'(bus_l.ser_ready), 32'(!m_pend[1]));
    chk("l_cnt",   32'(bus_l.bit_cnt),   32'(m_cnt[1]));
`ifdef SIPO_PARITY_EN
    chk("m_perr",  32'(bus_m.out_perr),  32'(m_operr[0]));
    chk("l_perr",  32'(bus_l.out_perr),  32'(m_operr[1]));
`endif
  endtask

  task automatic step(input logic sv, input logic b, input logic ordy, input logic clr);
    bus_m.ser_valid = sv; bus_m.ser_in = b; bus_m.out_ready = ordy;
    bus_l.ser_valid = sv; bus_l.ser_in = b; bus_l.out_ready = ordy;
    clear = clr;
    model_step(0, sv, b, ordy, clr);
    model_step(1, sv, b, ordy, clr);
    @(posedge clk);
    #1;
    check_models();
  endtask

  task automatic send_word(input logic [7:0] s, input logic p, input logic ordy);
    for (int i = 7; i >= 0; i--) step(1'b1, s[i], ordy, 1'b0);
`ifdef SIPO_PARITY_EN
    step(1'b1, p, ordy, 1'b0);
`else
    if (p === 1'bx) $display("parity argument unused");
`endif
  endtask

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 8'hA5};
    vecs[1] = '{8'h80, 8'h80, 8'h01};
    vecs[2] = '{8'h11, 8'h11, 8'h88};
    vecs[3] = '{8'h22, 8'h22, 8'h44};
    vecs[4] = '{8'h33, 8'h33, 8'hCC};
    vecs[5] = '{8'hF0, 8'hF0, 8'h0F};
    vecs[6] = '{8'h3C, 8'h3C, 8'h3C};
    vecs[7] = '{8'h01, 8'h01, 8'h80};

    bus_m.ser_valid = 1'b0; bus_m.ser_in = 1'b0; bus_m.out_ready = 1'b0;
    bus_l.ser_valid = 1'b0; bus_l.ser_in = 1'b0; bus_l.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_valid", 32'(bus_m.out_valid), 32'd0);
    chk("reset_data",  32'(bus_m.out_data),  32'h00);
    chk("reset_ready", 32'(bus_m.ser_ready), 32'd1);
    chk("reset_cnt",   32'(bus_m.bit_cnt),   32'd0);

    // Basic: valid rises on the last accepting edge, for one cycle
    send_word(8'hA5, ^8'hA5, 1'b1);
    chk("basic_valid", 32'(bus_m.out_valid), 32'd1);
    chk("basic_msb",   32'(bus_m.out_data),  32'hA5);
    chk("basic_lsb",   32'(bus_l.out_data),  32'hA5);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("basic_pulse", 32'(bus_m.out_valid), 32'd0);

    // Back-to-back table: continuous bits, every word a single pulse
    for (int i = 0; i < 8; i++) begin
      send_word(vecs[i].stream, ^vecs[i].stream, 1'b1);
      chk("tbl_valid", 32'(bus_m.out_valid), 32'd1);
      chk("tbl_msb",   32'(bus_m.out_data),  32'(vecs[i].exp_msb));
      chk("tbl_lsb",   32'(bus_l.out_data),  32'(vecs[i].exp_lsb));
      chk("tbl_ready", 32'(bus_m.ser_ready), 32'd1);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure: second word parks in the shift register
    send_word(8'h3C, ^8'h3C, 1'b0);
    chk("bp_first", 32'(bus_m.out_data), 32'h3C);
    send_word(8'hC3, ^8'hC3, 1'b0);
    chk("bp_full_ready", 32'(bus_m.ser_ready), 32'd0);
    chk("bp_full_data",  32'(bus_m.out_data),  32'h3C);
    chk("bp_full_cnt",   32'(bus_m.bit_cnt),   32'(NB));
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("bp_ignored", 32'(bus_m.bit_cnt), 32'(NB));
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_drain_data",  32'(bus_m.out_data),  32'hC3);
    chk("bp_drain_valid", 32'(bus_m.out_valid), 32'd1);
    chk("bp_drain_ready", 32'(bus_m.ser_ready), 32'd1);
    chk("bp_drain_cnt",   32'(bus_m.bit_cnt),   32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_consumed", 32'(bus_m.out_valid), 32'd0);

    // Clear after 5 bits with a held word pending consumption
    send_word(8'h96, ^8'h96, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'(i & 1), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_cnt",   32'(bus_m.bit_cnt),   32'd0);
    chk("clr_valid", 32'(bus_m.out_valid), 32'd0);
    send_word(8'h5A, ^8'h5A, 1'b1);
    chk("clr_after_msb", 32'(bus_m.out_data), 32'h5A);
    chk("clr_after_lsb", 32'(bus_l.out_data), 32'h5A);

`ifdef SIPO_PARITY_EN
    send_word(8'h07, 1'b1, 1'b1);
    chk("par_ok",  32'(bus_m.out_perr), 32'd0);
    send_word(8'h07, 1'b0, 1'b1);
    chk("par_bad", 32'(bus_m.out_perr), 32'd1);
`endif

    // Asynchronous reset while FULL, between clock edges
    step(1'b0, 1'b0, 1'b1, 1'b0);
    send_word(8'hE7, ^8'hE7, 1'b0);
    send_word(8'h18, ^8'h18, 1'b0);
    chk("rst_pre_full", 32'(bus_m.ser_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async_valid", 32'(bus_m.out_valid), 32'd0);
    chk("rst_async_data",  32'(bus_m.out_data),  32'h00);
    chk("rst_async_ready", 32'(bus_m.ser_ready), 32'd1);
    chk("rst_async_cnt",   32'(bus_m.bit_cnt),   32'd0);
    chk("rst_async_ldata", 32'(bus_l.out_data),  32'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           (n % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
           $urandom_range(0, 99) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
